// File: rtl/bcd_multi_counter_if.sv
// Button/switch inputs and 7-seg outputs of bcd_multi_counter, bundled as one port.
//   I_BTNU/L/C/R/D : raw push buttons, level
//   I_MODE         : run mode (00 up, 01 down, 10 Gray, 11 Johnson)
//   I_WRAP         : 1 = wrap at terminal value, 0 = saturate (up/down only)
//   O_LED7SEG      : digit i at [4i+3:4i], digit 0 is LSD
//   O_LEDDRVEN     : per-digit drive enable
//   O_LEDDOTS      : per-digit decimal point
//   O_TC           : one-cycle terminal-count pulse
//   O_STATE        : 00 IDLE, 01 SET, 10 RUN, 11 PAUSE
// master = side driving the pins (board / bench), slave = the counter.
interface bcd_multi_counter_if #(
  parameter int DIGITS = 4
);
  logic                  I_BTNU;
  logic                  I_BTNL;
  logic                  I_BTNC;
  logic                  I_BTNR;
  logic                  I_BTND;
  logic [1:0]            I_MODE;
  logic                  I_WRAP;
  logic [4*DIGITS-1:0]   O_LED7SEG;
  logic [DIGITS-1:0]     O_LEDDRVEN;
  logic [DIGITS-1:0]     O_LEDDOTS;
  logic                  O_TC;
  logic [1:0]            O_STATE;

  modport master (
    output I_BTNU, I_BTNL, I_BTNC, I_BTNR, I_BTND, I_MODE, I_WRAP,
    input  O_LED7SEG, O_LEDDRVEN, O_LEDDOTS, O_TC, O_STATE
  );

  modport slave (
    input  I_BTNU, I_BTNL, I_BTNC, I_BTNR, I_BTND, I_MODE, I_WRAP,
    output O_LED7SEG, O_LEDDRVEN, O_LEDDOTS, O_TC, O_STATE
  );
endinterface

// File: rtl/bcd_multi_counter.sv
// Multi-digit BCD counter with cursor editor and up/down/Gray/Johnson run modes.
//
// Ports:
//   I_CLK      : system clock, rising edge
//   I_RESET_N  : synchronous active-low reset
//   bus        : bcd_multi_counter_if.slave (buttons, mode, wrap, 7-seg outputs)
//
// Parameters:
//   DIGITS    : number of display digits (2..8)
//   TICK_DIV  : tick period is TICK_DIV+1 clocks
//   DIV_W     : divider width, 2**DIV_W > TICK_DIV
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, digits above the
// most significant nonzero digit are not driven in IDLE/RUN/PAUSE (digit 0
// always driven, SET unaffected).
//
// State table:
//   state | meaning
//   IDLE  | display held, waiting for C to start editing
//   SET   | cursor editing of digits (L/R move, U/D change digit)
//   RUN   | counting on each divider tick in the latched mode
//   PAUSE | counting frozen, C resumes, L returns to IDLE
module bcd_multi_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 195312,
  parameter int DIV_W    = 18
) (
  input  logic              I_CLK,
  input  logic              I_RESET_N,
  bcd_multi_counter_if.slave bus
);

  localparam int            CW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_GRAY = 2'b10;
  localparam logic [1:0] M_JOHN = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SET   = 2'b01,
    S_RUN   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Button conditioning: two-flop shift, registered rising-edge pulse.
  // Bit order {C, L, R, U, D}.
  // ---------------------------------------------------------------------------
  logic [4:0] btn_raw;
  logic [4:0] sync0_q, sync1_q, push_q;
  logic       btn_c, btn_l, btn_r, btn_u, btn_d;

  assign btn_raw = {bus.I_BTNC, bus.I_BTNL, bus.I_BTNR, bus.I_BTNU, bus.I_BTND};

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      sync0_q <= '0;
      sync1_q <= '0;
      push_q  <= '0;
    end else begin
      sync0_q <= btn_raw;
      sync1_q <= sync0_q;
      push_q  <= sync0_q & ~sync1_q;
    end
  end

  // Only the highest-priority pulse acts: C > L > R > U > D.
  assign btn_c = push_q[4];
  assign btn_l = push_q[3] & ~push_q[4];
  assign btn_r = push_q[2] & ~|push_q[4:3];
  assign btn_u = push_q[1] & ~|push_q[4:2];
  assign btn_d = push_q[0] & ~|push_q[4:1];

  // ---------------------------------------------------------------------------
  // Tick divider and blink, free-running in every state.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             blink_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(TICK_DIV));

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      div_q   <= '0;
      blink_q <= 1'b0;
    end else if (tick) begin
      div_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0]       cursor_q, cursor_d;
  logic [DIGITS-1:0]   gray_q, gray_d;
  logic [DIGITS-1:0]   john_q, john_d;
  logic [1:0]          mode_q, mode_d;
  logic                wrap_q, wrap_d;
  logic                tc_q, tc_d;
  logic [DIGITS-1:0]   drven_q, drven_d;
  logic [DIGITS-1:0]   dots_q, dots_d;
  logic                sat_stop;
  logic                enter_run;

  // BCD increment/decrement of the whole value with ripple carry/borrow.
  logic [4*DIGITS-1:0] inc_val, dec_val;
  logic                all9, all0, inc_all9, dec_all0;
  logic                carry, borrow;
  logic [3:0]          nib;

  always_comb begin
    inc_val  = digits_q;
    dec_val  = digits_q;
    carry    = 1'b1;
    borrow   = 1'b1;
    all9     = 1'b1;
    all0     = 1'b1;
    inc_all9 = 1'b1;
    dec_all0 = 1'b1;
    nib      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = digits_q[4*i +: 4];
      if (nib != 4'd9) all9 = 1'b0;
      if (nib != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (nib == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = nib + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (nib == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = nib - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_val[4*i +: 4] != 4'd9) inc_all9 = 1'b0;
      if (dec_val[4*i +: 4] != 4'd0) dec_all0 = 1'b0;
    end
  end

  logic [3:0]        cur_digit;
  logic [DIGITS-1:0] gray_code;
  logic [DIGITS-1:0] john_next;

  assign cur_digit = digits_q[{cursor_q, 2'b00} +: 4];
  assign gray_code = gray_q ^ (gray_q >> 1);
  assign john_next = {john_q[DIGITS-2:0], ~john_q[DIGITS-1]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (btn_c) state_d = S_SET;
      S_SET:   if (btn_c) state_d = S_RUN;
      S_RUN: begin
        if (btn_c || sat_stop) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (btn_c)      state_d = S_RUN;
        else if (btn_l) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_run = (state_d == S_RUN) && (state_q != S_RUN);

  // Datapath next-state: editing in SET, counting on ticks in RUN.
  always_comb begin
    digits_d = digits_q;
    cursor_d = cursor_q;
    gray_d   = gray_q;
    john_d   = john_q;
    tc_d     = 1'b0;
    sat_stop = 1'b0;
    mode_d   = enter_run ? bus.I_MODE : mode_q;
    wrap_d   = enter_run ? bus.I_WRAP : wrap_q;
    case (state_q)
      S_IDLE: begin
        if (btn_c) cursor_d = CUR_MAX;
      end
      S_SET: begin
        if (btn_c) begin
          gray_d = '0;
          john_d = '0;
        end else if (btn_l) begin
          if (cursor_q != CUR_MAX) cursor_d = cursor_q + 1'b1;
        end else if (btn_r) begin
          if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
        end else if (btn_u) begin
          if (cur_digit != 4'd9) digits_d[{cursor_q, 2'b00} +: 4] = cur_digit + 4'd1;
        end else if (btn_d) begin
          if (cur_digit != 4'd0) digits_d[{cursor_q, 2'b00} +: 4] = cur_digit - 4'd1;
        end
      end
      S_RUN: begin
        if (tick) begin
          case (mode_q)
            M_UP: begin
              if (all9) begin
                // Already at terminal: wrap to zero, or hold silently when saturating.
                if (wrap_q) begin
                  digits_d = '0;
                  tc_d     = 1'b1;
                end
              end else begin
                digits_d = inc_val;
                if (!wrap_q && inc_all9) begin
                  tc_d     = 1'b1;
                  sat_stop = 1'b1;
                end
              end
            end
            M_DOWN: begin
              if (all0) begin
                if (wrap_q) begin
                  for (int i = 0; i < DIGITS; i++) digits_d[4*i +: 4] = 4'd9;
                  tc_d = 1'b1;
                end
              end else begin
                digits_d = dec_val;
                if (!wrap_q && dec_all0) begin
                  tc_d     = 1'b1;
                  sat_stop = 1'b1;
                end
              end
            end
            M_GRAY: begin
              // Display shows the code of the pre-advance count.
              for (int i = 0; i < DIGITS; i++) digits_d[4*i +: 4] = {3'b000, gray_code[i]};
              gray_d = gray_q + 1'b1;
              if (&gray_q) tc_d = 1'b1;
            end
            default: begin
              for (int i = 0; i < DIGITS; i++) digits_d[4*i +: 4] = {3'b000, john_q[i]};
              john_d = john_next;
              if (john_next == '0) tc_d = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask: bit i set when digit i may be driven.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] lz_keep;

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;
  always_comb begin
    lz_keep = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (digits_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      lz_keep[i] = seen_nz || (i == 0);
    end
  end
`else
  assign lz_keep = '1;
`endif

  // FSM: output logic (drive enables and dots, registered below)
  always_comb begin
    drven_d = '0;
    dots_d  = '0;
    case (state_q)
      S_SET: begin
        for (int i = 0; i < DIGITS; i++) begin
          drven_d[i] = (cursor_q == CW'(i)) ? 1'b1 : blink_q;
          dots_d[i]  = (cursor_q == CW'(i));
        end
      end
      S_PAUSE: begin
        drven_d = {DIGITS{blink_q}} & lz_keep;
        dots_d  = '1;
      end
      default: begin
        drven_d = lz_keep;
        dots_d  = '0;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      digits_q <= '0;
      cursor_q <= CUR_MAX;
      gray_q   <= '0;
      john_q   <= '0;
      mode_q   <= '0;
      wrap_q   <= 1'b0;
      tc_q     <= 1'b0;
      drven_q  <= '0;
      dots_q   <= '0;
    end else begin
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      gray_q   <= gray_d;
      john_q   <= john_d;
      mode_q   <= mode_d;
      wrap_q   <= wrap_d;
      tc_q     <= tc_d;
      drven_q  <= drven_d;
      dots_q   <= dots_d;
    end
  end

  assign bus.O_LED7SEG  = digits_q;
  assign bus.O_LEDDRVEN = drven_q;
  assign bus.O_LEDDOTS  = dots_q;
  assign bus.O_TC       = tc_q;
  assign bus.O_STATE    = state_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed bench for bcd_multi_counter with DIGITS=4, TICK_DIV=3.
module tb_bcd_multi_counter;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_multi_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_multi_counter #(.DIGITS(DIGITS), .TICK_DIV(3), .DIV_W(2)) dut (
    .I_CLK    (clk),
    .I_RESET_N(rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;   // rising edges since reset release; tick edges are cyc % 4 == 0
  int tc_cnt   = 0;
  int tc_base;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (bus.O_TC === 1'b1) tc_cnt <= tc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // m = {C, L, R, U, D}; returns at the negedge right after the action edge.
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    {bus.I_BTNC, bus.I_BTNL, bus.I_BTNR, bus.I_BTNU, bus.I_BTND} = m;
    repeat (3) @(negedge clk);
    {bus.I_BTNC, bus.I_BTNL, bus.I_BTNR, bus.I_BTNU, bus.I_BTND} = 5'b0;
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    for (int k = 0; k < n; k++) press(m);
  endtask

  // Advance to the negedge just after the next tick edge.
  task automatic wait_tick(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((cyc % 4) != 0 && guard < 12);
    if ((cyc % 4) != 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: tick not reached within 12 cycles", tag);
    end
  endtask

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  logic [15:0] john_exp [8];

  initial begin
    john_exp[0] = 16'h0000; john_exp[1] = 16'h0001;
    john_exp[2] = 16'h0011; john_exp[3] = 16'h0111;
    john_exp[4] = 16'h1111; john_exp[5] = 16'h1110;
    john_exp[6] = 16'h1100; john_exp[7] = 16'h1000;

    {bus.I_BTNC, bus.I_BTNL, bus.I_BTNR, bus.I_BTNU, bus.I_BTND} = 5'b0;
    bus.I_MODE = 2'b00;
    bus.I_WRAP = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", bus.O_LED7SEG, 16'h0000);
    chk("rst_state", bus.O_STATE, 2'b00);
    chk("rst_tc", bus.O_TC, 1'b0);
    chk("rst_drven", bus.O_LEDDRVEN, 4'h0);
    chk("rst_dots", bus.O_LEDDOTS, 4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_drven", bus.O_LEDDRVEN, 4'hF);
    chk("idle_dots", bus.O_LEDDOTS, 4'h0);

    // SET editing
    press(B_C);
    chk("set_state", bus.O_STATE, 2'b01);
    @(negedge clk);
    chk("set_dots_msd", bus.O_LEDDOTS, 4'b1000);
    chk("set_drv_cursor", bus.O_LEDDRVEN[3], 1'b1);
    press_n(B_U, 3);
    press(B_R);
    press_n(B_U, 12);
    press(B_R);
    press(B_D);
    chk("edit_3900", bus.O_LED7SEG, 16'h3900);
    press_n(B_R, 3);
    press(B_U);
    chk("cursor_clamp0", bus.O_LED7SEG, 16'h3901);
    @(negedge clk);
    chk("set_dots_lsd", bus.O_LEDDOTS, 4'b0001);
    press_n(B_L, 5);
    press(B_U);
    chk("cursor_clamp_max", bus.O_LED7SEG, 16'h4901);

    // Build 9998
    press_n(B_U, 6);
    press(B_R);
    press(B_R);
    press_n(B_U, 9);
    press(B_R);
    press_n(B_U, 7);
    chk("edit_9998", bus.O_LED7SEG, 16'h9998);

    // Up with wrap; mode change during RUN must be ignored
    bus.I_MODE = 2'b00;
    bus.I_WRAP = 1'b1;
    tc_base = tc_cnt;
    press(B_C);
    chk("run_state", bus.O_STATE, 2'b10);
    wait_tick("up_t1");
    chk("up_9999", bus.O_LED7SEG, 16'h9999);
    chk("up_t1_tc", bus.O_TC, 1'b0);
    bus.I_MODE = 2'b01;
    bus.I_WRAP = 1'b0;
    wait_tick("up_t2");
    chk("up_wrap_0000", bus.O_LED7SEG, 16'h0000);
    chk("up_wrap_tc", bus.O_TC, 1'b1);
    wait_tick("up_t3");
    chk("up_latched_0001", bus.O_LED7SEG, 16'h0001);
    chk("up_tc_once", tc_cnt - tc_base, 1);
    // One more tick lands strictly before the pause takes effect.
    @(negedge clk);
    press(B_C);
    chk("pause_state", bus.O_STATE, 2'b11);
    chk("pause_0002", bus.O_LED7SEG, 16'h0002);
    @(negedge clk);
    chk("pause_dots", bus.O_LEDDOTS, 4'hF);

    // Down with saturate from 0002 (resume relatches mode/wrap)
    bus.I_MODE = 2'b01;
    bus.I_WRAP = 1'b0;
    tc_base = tc_cnt;
    press(B_C);
    chk("resume_state", bus.O_STATE, 2'b10);
    wait_tick("dn_t1");
    chk("dn_0001", bus.O_LED7SEG, 16'h0001);
    chk("dn_t1_tc", bus.O_TC, 1'b0);
    wait_tick("dn_t2");
    chk("dn_sat_0000", bus.O_LED7SEG, 16'h0000);
    chk("dn_sat_tc", bus.O_TC, 1'b1);
    chk("dn_sat_pause", bus.O_STATE, 2'b11);
    wait_tick("dn_t3");
    wait_tick("dn_t4");
    chk("dn_hold_0000", bus.O_LED7SEG, 16'h0000);
    chk("dn_tc_once", tc_cnt - tc_base, 1);

    // Johnson from a SET entry
    press(B_L);
    chk("pause_to_idle", bus.O_STATE, 2'b00);
    press(B_C);
    bus.I_MODE = 2'b11;
    press(B_C);
    chk("john_run", bus.O_STATE, 2'b10);
    for (int k = 0; k < 8; k++) begin
      wait_tick("john_tick");
      chk($sformatf("john_pat%0d", k + 1), bus.O_LED7SEG, {16'h0, john_exp[k]});
      chk($sformatf("john_tc%0d", k + 1), bus.O_TC, (k == 7) ? 1'b1 : 1'b0);
    end

    // Simultaneous C+U in SET: only C acts
    @(negedge clk);
    press(B_C);
    press(B_L);
    press(B_C);
    chk("set_again", bus.O_STATE, 2'b01);
    press(B_U);
    chk("set_u_1000", bus.O_LED7SEG, 16'h1000);
    press(B_C | B_U);
    chk("cu_state_run", bus.O_STATE, 2'b10);
    chk("cu_digit_kept", bus.O_LED7SEG, 16'h1000);

    // Holding C gives a single transition
    @(negedge clk);
    bus.I_BTNC = 1'b1;
    repeat (50) @(negedge clk);
    bus.I_BTNC = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_c_once", bus.O_STATE, 2'b11);

    // Reset in the middle of RUN
    press(B_C);
    chk("run_before_rst", bus.O_STATE, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_led", bus.O_LED7SEG, 16'h0000);
    chk("midrst_state", bus.O_STATE, 2'b00);
    chk("midrst_tc", bus.O_TC, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
